inst_mem_writer: RTL and testbench

- Write side of the byte-addressed instruction memory: accepts 32-bit word write requests over a valid/ready handshake and serialises each into four little-endian byte writes, one byte per clock.
- Also provides the combinational fetch read port (4-byte little-endian assembly), so a loader or debug port can patch program memory while the pipeline fetches from the same array.
- Sits between the program loader / testbench driver and the IF stage.

---
 rtl/inst_mem_writer_pkg.sv | 22 ++
 rtl/inst_mem_writer_byte_ram.sv | 32 +++
 rtl/inst_mem_writer.sv | 109 ++++++++++
 tb/tb_inst_mem_writer.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/inst_mem_writer_pkg.sv
// Shared types and byte-lane constants for the instruction-memory writer.
// Words are little-endian: lane 0 is bits [7:0] and lands at the lowest address.
package inst_mem_writer_pkg;

  typedef enum logic [0:0] {
    StIdle,
    StWrite
  } state_e;

  localparam int unsigned BYTES_PER_WORD = 4;
  localparam int unsigned BYTE_W         = 8;
  localparam int unsigned WORD_W         = BYTES_PER_WORD * BYTE_W;
  localparam int unsigned LANE_IDX_W     = 2;

  localparam logic [LANE_IDX_W-1:0] LastLane = LANE_IDX_W'(BYTES_PER_WORD - 1);

  function automatic logic [BYTE_W-1:0] get_lane(input logic [WORD_W-1:0]     word,
                                                  input logic [LANE_IDX_W-1:0] idx);
    return word[BYTE_W*idx +: BYTE_W];
  endfunction

endpackage

// File: rtl/inst_mem_writer_byte_ram.sv
// Byte-wide RAM with one synchronous write port and a combinational
// little-endian word read port; read addresses wrap modulo the depth.
module inst_mem_writer_byte_ram
  import inst_mem_writer_pkg::*;
#(
  parameter int unsigned ADDR_W = 16
) (
  input  logic              clk_i,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [BYTE_W-1:0] wdata_i,
  input  logic [ADDR_W-1:0] raddr_i,
  output logic [WORD_W-1:0] rdata_o
);

  // Contents are deliberately not reset: a reset must not wipe a loaded program.
  logic [BYTE_W-1:0] mem [2**ADDR_W];

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem[waddr_i] <= wdata_i;
    end
  end

  always_comb begin
    rdata_o = '0;
    for (int i = 0; i < BYTES_PER_WORD; i++) begin
      rdata_o[BYTE_W*i +: BYTE_W] = mem[raddr_i + ADDR_W'(i)];
    end
  end

endmodule

// File: rtl/inst_mem_writer.sv
// Serialises 32-bit word writes into four byte writes (one per clock) on the
// instruction memory, and exposes the combinational fetch read port.
module inst_mem_writer
  import inst_mem_writer_pkg::*;
#(
  parameter int unsigned ADDR_W      = 16,
  parameter bit          ALIGN_CHECK = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wr_valid,
  output logic        wr_ready,
  input  logic [31:0] wr_adr,
  input  logic [31:0] wr_data,
  output logic        wr_done,
  output logic        err,
  output logic        busy,
  input  logic [31:0] rd_adr,
  output logic [31:0] rd_data
);

  state_e                  state_q, state_d;
  logic [LANE_IDX_W-1:0]   cnt_q, cnt_d;
  logic [ADDR_W-1:0]       base_q, base_d;
  logic [WORD_W-1:0]       data_q, data_d;
  logic                    done_q, done_d;
  logic                    err_q, err_d;

  logic                    mem_we;
  logic [ADDR_W-1:0]       mem_waddr;
  logic [BYTE_W-1:0]       mem_wdata;

  // Upper address bits are outside the implemented array.
  logic unused_adr_bits;
  assign unused_adr_bits = ^{wr_adr[31:ADDR_W], rd_adr[31:ADDR_W]};

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    base_d  = base_q;
    data_d  = data_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    mem_we  = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (wr_valid) begin
          base_d = wr_adr[ADDR_W-1:0];
          data_d = wr_data;
          if (ALIGN_CHECK && (wr_adr[1:0] != 2'b00)) begin
            err_d = 1'b1;
          end else begin
            state_d = StWrite;
            cnt_d   = '0;
          end
        end
      end
      StWrite: begin
        mem_we = 1'b1;
        cnt_d  = cnt_q + 1'b1;
        if (cnt_q == LastLane) begin
          state_d = StIdle;
          done_d  = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      base_q  <= '0;
      data_q  <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      base_q  <= base_d;
      data_q  <= data_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  // Address arithmetic stays in ADDR_W bits so a word straddling the top wraps to 0.
  assign mem_waddr = base_q + {{(ADDR_W-LANE_IDX_W){1'b0}}, cnt_q};
  assign mem_wdata = get_lane(data_q, cnt_q);

  assign wr_ready = (state_q == StIdle);
  assign busy     = (state_q == StWrite);
  assign wr_done  = done_q;
  assign err      = err_q;

  inst_mem_writer_byte_ram #(
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clk_i   (clk),
    .we_i    (mem_we),
    .waddr_i (mem_waddr),
    .wdata_i (mem_wdata),
    .raddr_i (rd_adr[ADDR_W-1:0]),
    .rdata_o (rd_data)
  );

endmodule

// File: tb/tb_inst_mem_writer.sv
// Self-checking bench: table of word writes on an aligned and an unaligned
// instance, plus hand-written sequences for progress, back-to-back and reset.
module tb_inst_mem_writer;

  logic        clk = 1'b0;
  logic        rst;

  logic        a_wr_valid, a_wr_ready, a_wr_done, a_err, a_busy;
  logic [31:0] a_wr_adr, a_wr_data, a_rd_adr, a_rd_data;
  logic        b_wr_valid, b_wr_ready, b_wr_done, b_err, b_busy;
  logic [31:0] b_wr_adr, b_wr_data, b_rd_adr, b_rd_data;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  inst_mem_writer #(.ADDR_W(16), .ALIGN_CHECK(1'b1)) u_dut_a (
    .clk      (clk),
    .rst      (rst),
    .wr_valid (a_wr_valid),
    .wr_ready (a_wr_ready),
    .wr_adr   (a_wr_adr),
    .wr_data  (a_wr_data),
    .wr_done  (a_wr_done),
    .err      (a_err),
    .busy     (a_busy),
    .rd_adr   (a_rd_adr),
    .rd_data  (a_rd_data)
  );

  inst_mem_writer #(.ADDR_W(16), .ALIGN_CHECK(1'b0)) u_dut_b (
    .clk      (clk),
    .rst      (rst),
    .wr_valid (b_wr_valid),
    .wr_ready (b_wr_ready),
    .wr_adr   (b_wr_adr),
    .wr_data  (b_wr_data),
    .wr_done  (b_wr_done),
    .err      (b_err),
    .busy     (b_busy),
    .rd_adr   (b_rd_adr),
    .rd_data  (b_rd_data)
  );

  typedef struct {
    bit          sel;      // 0: ALIGN_CHECK=1 instance, 1: ALIGN_CHECK=0 instance
    logic [31:0] adr;
    logic [31:0] data;
    bit          exp_err;
    logic [31:0] rd_adr;
    logic [31:0] exp_rd;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic drive(input bit sel, input logic v, input logic [31:0] adr,
                       input logic [31:0] data);
    if (sel) begin
      b_wr_valid = v; b_wr_adr = adr; b_wr_data = data;
    end else begin
      a_wr_valid = v; a_wr_adr = adr; a_wr_data = data;
    end
  endtask

  task automatic read(input bit sel, input logic [31:0] adr, output logic [31:0] data);
    if (sel) b_rd_adr = adr; else a_rd_adr = adr;
    #1;
    data = sel ? b_rd_data : a_rd_data;
  endtask

  // Presents one request, lets it be accepted at the next edge, then counts the
  // edges until wr_done is visible (bounded). lat=4 means done in the 5th cycle.
  task automatic do_write(input bit sel, input logic [31:0] adr, input logic [31:0] data,
                          output int lat, output logic got_err);
    drive(sel, 1'b1, adr, data);
    @(posedge clk); #1;
    drive(sel, 1'b0, 32'h0, 32'h0);
    got_err = sel ? b_err : a_err;
    lat = 0;
    if (!got_err) begin
      while (!(sel ? b_wr_done : a_wr_done) && lat < 10) begin
        @(posedge clk); #1;
        lat++;
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    vec_t        vecs [8];
    logic [31:0] exp_prog [5];
    logic [31:0] rd;
    int          lat;
    logic        got_err;
    int          n_low;
    logic        saw_done;

    vecs[0] = '{1'b0, 32'h0000_0000, 32'h8C01_0004, 1'b0, 32'h0000_0000, 32'h8C01_0004};
    vecs[1] = '{1'b0, 32'h0000_0010, 32'h1122_3344, 1'b0, 32'h0000_0010, 32'h1122_3344};
    vecs[2] = '{1'b0, 32'h0000_0004, 32'hCAFE_F00D, 1'b0, 32'h0000_0004, 32'hCAFE_F00D};
    vecs[3] = '{1'b0, 32'h0000_0006, 32'h1234_5678, 1'b1, 32'h0000_0004, 32'hCAFE_F00D};
    vecs[4] = '{1'b0, 32'h0000_0020, 32'h0000_0000, 1'b0, 32'h0000_0020, 32'h0000_0000};
    vecs[5] = '{1'b1, 32'h0000_FFFE, 32'h0102_0304, 1'b0, 32'h0000_FFFE, 32'h0102_0304};
    vecs[6] = '{1'b1, 32'h0000_0003, 32'hA1B2_C3D4, 1'b0, 32'h0000_0003, 32'hA1B2_C3D4};
    vecs[7] = '{1'b0, 32'h0000_FFFF, 32'h5555_AAAA, 1'b1, 32'h0000_0000, 32'h8C01_0004};

    exp_prog[0] = 32'h1122_3344;
    exp_prog[1] = 32'h1122_33DD;
    exp_prog[2] = 32'h1122_CCDD;
    exp_prog[3] = 32'h11BB_CCDD;
    exp_prog[4] = 32'hAABB_CCDD;

    rst = 1'b1;
    drive(1'b0, 1'b0, 32'h0, 32'h0);
    drive(1'b1, 1'b0, 32'h0, 32'h0);
    a_rd_adr = 32'h0;
    b_rd_adr = 32'h0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_ready", a_wr_ready, 1);
    check("reset_busy", a_busy, 0);
    check("reset_done", a_wr_done, 0);
    check("reset_err", a_err, 0);
    check("reset_ready_b", b_wr_ready, 1);
    rst = 1'b0;
    @(posedge clk); #1;

    // Table of word writes.
    for (int i = 0; i < 8; i++) begin
      do_write(vecs[i].sel, vecs[i].adr, vecs[i].data, lat, got_err);
      check($sformatf("vec%0d_err", i), got_err, vecs[i].exp_err);
      if (vecs[i].exp_err) begin
        check($sformatf("vec%0d_err_ready", i), vecs[i].sel ? b_wr_ready : a_wr_ready, 1);
        check($sformatf("vec%0d_err_nodone", i), vecs[i].sel ? b_wr_done : a_wr_done, 0);
        @(posedge clk); #1;
        check($sformatf("vec%0d_err_pulse", i), vecs[i].sel ? b_err : a_err, 0);
      end else begin
        check($sformatf("vec%0d_latency", i), lat, 4);
        check($sformatf("vec%0d_done_ready", i), vecs[i].sel ? b_wr_ready : a_wr_ready, 1);
        @(posedge clk); #1;
        check($sformatf("vec%0d_done_pulse", i), vecs[i].sel ? b_wr_done : a_wr_done, 0);
      end
      read(vecs[i].sel, vecs[i].rd_adr, rd);
      check($sformatf("vec%0d_rd", i), rd, vecs[i].exp_rd);
    end

    // Byte placement: mem[1..4] = 00 01 8C 0D on the aligned instance.
    read(1'b0, 32'h1, rd);
    check("bytes_0_to_4", rd, 32'h0D8C_0100);
    // Wrap bytes on the unaligned instance.
    read(1'b1, 32'hFFFF, rd);
    check("wrap_ffff", rd & 32'h00FF_FFFF, 32'h0001_0203);
    read(1'b1, 32'h0000, rd);
    check("wrap_0000", rd & 32'h0000_FFFF, 32'h0000_0102);

    // Per-edge progress over 0x11223344 at 0x10.
    drive(1'b0, 1'b1, 32'h10, 32'hAABB_CCDD);
    @(posedge clk); #1;
    drive(1'b0, 1'b0, 32'h0, 32'h0);
    for (int e = 0; e < 5; e++) begin
      if (e > 0) begin
        @(posedge clk); #1;
      end
      read(1'b0, 32'h10, rd);
      check($sformatf("progress_%0d", e), rd, exp_prog[e]);
      check($sformatf("progress_done_%0d", e), a_wr_done, (e == 4));
      check($sformatf("progress_ready_%0d", e), a_wr_ready, (e == 4));
    end
    @(posedge clk); #1;
    check("progress_done_drop", a_wr_done, 0);

    // Back-to-back with wr_valid held high.
    drive(1'b0, 1'b1, 32'h40, 32'h0123_4567);
    @(posedge clk); #1;
    check("b2b_first_busy", a_busy, 1);
    drive(1'b0, 1'b1, 32'h44, 32'h89AB_CDEF);
    n_low = 0;
    for (int c = 0; c < 4; c++) begin
      if (!a_wr_ready) n_low++;
      @(posedge clk); #1;
    end
    check("b2b_ready_low_cycles", n_low, 4);
    check("b2b_first_done", a_wr_done, 1);
    check("b2b_ready_back", a_wr_ready, 1);
    read(1'b0, 32'h40, rd);
    check("b2b_first_word", rd, 32'h0123_4567);
    @(posedge clk); #1;
    check("b2b_second_accept", a_busy, 1);
    drive(1'b0, 1'b0, 32'h0, 32'h0);
    lat = 0;
    while (!a_wr_done && lat < 10) begin
      @(posedge clk); #1;
      lat++;
    end
    check("b2b_second_latency", lat, 4);
    read(1'b0, 32'h44, rd);
    check("b2b_second_word", rd, 32'h89AB_CDEF);
    read(1'b0, 32'h40, rd);
    check("b2b_first_intact", rd, 32'h0123_4567);
    @(posedge clk); #1;

    // Reset after two byte writes of 0xDEADBEEF over zeros at 0x20.
    drive(1'b0, 1'b1, 32'h20, 32'hDEAD_BEEF);
    @(posedge clk); #1;
    drive(1'b0, 1'b0, 32'h0, 32'h0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    check("rst_async_ready", a_wr_ready, 1);
    check("rst_async_busy", a_busy, 0);
    check("rst_async_done", a_wr_done, 0);
    check("rst_async_err", a_err, 0);
    saw_done = 1'b0;
    repeat (2) begin
      @(posedge clk); #1;
      saw_done |= a_wr_done;
    end
    rst = 1'b0;
    read(1'b0, 32'h20, rd);
    check("rst_partial_word", rd, 32'h0000_BEEF);
    for (int c = 0; c < 6; c++) begin
      @(posedge clk); #1;
      saw_done |= a_wr_done;
    end
    check("rst_no_done", saw_done, 0);
    read(1'b0, 32'h20, rd);
    check("rst_word_stable", rd, 32'h0000_BEEF);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
